uart_rx: RTL and testbench

UART receiver that deserialises an asynchronous 8N1-style serial line into parallel words. It is the receive-side counterpart of the transmitter and consumes the serial stream that a uart_tx instance produces. Output is a valid/ready stream interface with a one-word holding register. Framing and overrun conditions are reported as single-cycle pulses.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1-style asynchronous serial receiver.
//
// Deserialises an idle-high serial line into DLEN-bit words (LSB first,
// no parity, one stop bit) and presents them on a valid/ready stream with
// a one-word holding register.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   i_rxs        asynchronous serial line, idle high
//   o_tvalid     received word available in the holding register
//   i_tready     consumer accepts the word in the holding register
//   o_tdata      received word
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: completed word dropped, holding register full
module uart_rx #(
  parameter int BAUD = 921600,
  parameter int CLKF = 100000000,
  parameter int DLEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rxs,
  output logic            o_tvalid,
  input  logic            i_tready,
  output logic [DLEN-1:0] o_tdata,
  output logic            o_frame_err,
  output logic            o_overrun
);

  localparam int BAUD_LIMIT = CLKF / BAUD - 1;
  localparam int HALF_LIMIT = BAUD_LIMIT / 2;
  localparam int CW         = $clog2(BAUD_LIMIT + 1);
  localparam int BW         = $clog2(DLEN + 1);

  localparam logic [CW-1:0] BAUD_LIM = CW'(BAUD_LIMIT);
  localparam logic [CW-1:0] HALF_LIM = CW'(HALF_LIMIT);
  localparam logic [BW-1:0] LAST_BIT = BW'(DLEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   baud_cnt_reg, baud_cnt_next;
  logic [BW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [DLEN-1:0] shift_reg, shift_next;
  logic            deliver_reg, deliver_next;
  logic            frame_err_reg, frame_err_next;
  logic            overrun_reg;
  logic            tvalid_reg;
  logic [DLEN-1:0] tdata_reg;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // release never looks like a start-bit edge.
  logic rx_meta_reg, rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= i_rxs;
      rx_s        <= rx_meta_reg;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      deliver_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      deliver_reg   <= deliver_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state logic. Counters default to zero, so every transition and the
  // IDLE/BREAK states leave them cleared without extra assignments.
  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = '0;
    bit_cnt_next   = '0;
    shift_next     = shift_reg;
    deliver_next   = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) state_next = ST_START;
      end
      ST_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (baud_cnt_reg == HALF_LIM) begin
          state_next = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      ST_DATA: begin
        bit_cnt_next = bit_cnt_reg;
        if (baud_cnt_reg == BAUD_LIM) begin
          // LSB arrives first: shifting right leaves it at bit 0 after DLEN samples.
          shift_next = {rx_s, shift_reg[DLEN-1:1]};
          if (bit_cnt_reg == LAST_BIT) begin
            state_next   = ST_STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt_reg == BAUD_LIM) begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (rx_s) begin
            deliver_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + CW'(1);
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before another frame is decoded.
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Holding register and stream handshake. A delivery may reload the register
  // in the same cycle the consumer takes the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_reg  <= 1'b0;
      tdata_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (deliver_reg && (!tvalid_reg || i_tready)) begin
        tvalid_reg <= 1'b1;
        tdata_reg  <= shift_reg;
      end else begin
        if (tvalid_reg && i_tready) tvalid_reg <= 1'b0;
        if (deliver_reg) overrun_reg <= 1'b1;
      end
    end
  end

  assign o_tvalid    = tvalid_reg;
  assign o_tdata     = tdata_reg;
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at default parameters.
// Serial frames are driven on the falling clock edge; expected words are
// queued when a frame is sent and compared as the DUT hands them over.
module tb_uart_rx;

  localparam int BAUD     = 921600;
  localparam int CLKF     = 100000000;
  localparam int DLEN     = 8;
  localparam int BIT_CLKS = CLKF / BAUD;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_rxs = 1'b1;
  logic            i_tready = 1'b1;
  logic            o_tvalid;
  logic [DLEN-1:0] o_tdata;
  logic            o_frame_err;
  logic            o_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_words  = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [DLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.BAUD(BAUD), .CLKF(CLKF), .DLEN(DLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rxs      (i_rxs),
    .o_tvalid   (o_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    i_rxs = b;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DLEN-1:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DLEN; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 i_tready = r;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: i_tready only changes just after a rising edge, so values seen
  // on the falling edge are the ones the next rising edge acts upon.
  initial begin
    logic [DLEN-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_frame_err) fe_cnt++;
        if (o_overrun) ov_cnt++;
        if (o_frame_err || o_overrun)
          check_eq("err_exclusive", 32'(o_frame_err & o_overrun), 32'd0);
        if (o_tvalid && i_tready) begin
          n_words++;
          $display("rx word 0x%02h (queued %0d)", o_tdata, exp_q.size());
          check_eq("word_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check_eq("rx_word", 32'(o_tdata), 32'(exp_w));
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int words_before;
    int fe_before;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", 32'(o_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(o_tdata), 32'd0);
    check_eq("rst_frame_err", 32'(o_frame_err), 32'd0);
    check_eq("rst_overrun", 32'(o_overrun), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain("drain_a5", 4 * BIT_CLKS);
    check_eq("a5_frame_err_cnt", 32'(fe_cnt), 32'd0);
    check_eq("a5_overrun_cnt", 32'(ov_cnt), 32'd0);
    repeat (BIT_CLKS) @(negedge clk);

    // Back-to-back frames, no idle gap
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("drain_b2b", 4 * BIT_CLKS);
    check_eq("b2b_frame_err_cnt", 32'(fe_cnt), 32'd0);
    repeat (BIT_CLKS) @(negedge clk);

    // Short glitch on an idle line
    words_before = n_words;
    @(negedge clk) i_rxs = 1'b0;
    repeat (20) @(negedge clk);
    i_rxs = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_eq("glitch_words", 32'(n_words), 32'(words_before));
    check_eq("glitch_tvalid", 32'(o_tvalid), 32'd0);
    check_eq("glitch_frame_err_cnt", 32'(fe_cnt), 32'd0);

    // Framing error followed by a held-low break
    words_before = n_words;
    fe_before = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (500) @(negedge clk);
    i_rxs = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_eq("break_frame_err_cnt", 32'(fe_cnt), 32'(fe_before + 1));
    check_eq("break_words", 32'(n_words), 32'(words_before));
    check_eq("break_tvalid", 32'(o_tvalid), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_drain("drain_5a", 4 * BIT_CLKS);
    repeat (BIT_CLKS) @(negedge clk);

    // Overrun with the consumer stalled
    set_ready(1'b0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    check_eq("ovr_tvalid_held", 32'(o_tvalid), 32'd1);
    check_eq("ovr_tdata_held", 32'(o_tdata), 32'h11);
    check_eq("ovr_overrun_cnt", 32'(ov_cnt), 32'd1);
    check_eq("ovr_frame_err_cnt", 32'(fe_cnt), 32'(fe_before + 1));
    set_ready(1'b1);
    wait_drain("drain_ovr", 10);
    repeat (3) @(negedge clk);
    check_eq("ovr_tvalid_drop", 32'(o_tvalid), 32'd0);
    repeat (BIT_CLKS) @(negedge clk);

    // Reset in the middle of bit 3 of 0x96
    words_before = n_words;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk) i_rxs = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_tvalid", 32'(o_tvalid), 32'd0);
    check_eq("mid_rst_tdata", 32'(o_tdata), 32'd0);
    check_eq("mid_rst_frame_err", 32'(o_frame_err), 32'd0);
    check_eq("mid_rst_overrun", 32'(o_overrun), 32'd0);
    rst = 1'b0;
    i_rxs = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_eq("mid_rst_no_junk", 32'(n_words), 32'(words_before));
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_drain("drain_c3", 4 * BIT_CLKS);
    check_eq("c3_words", 32'(n_words), 32'(words_before + 1));
    repeat (BIT_CLKS) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
